// File: rtl/ray_pkg.sv
// Shared ray-pipeline types: 3-component vector (also used by the stepper) and generator FSM state.
package ray_pkg;
  localparam int RAY_WIDTH = 16;

  typedef logic [2:0][RAY_WIDTH-1:0] vec3_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    EMIT,
    DONE
  } gen_state_t;
endpackage

// File: rtl/ray_generator_if.sv
// Ray output channel: valid/ready handshake carrying origin q, direction v and pixel coordinates.
interface ray_generator_if #(
  parameter int WIDTH  = 16,
  parameter int H_BITS = 7,
  parameter int V_BITS = 7
);
  logic                  rayValid;
  logic                  rayReady;
  logic [2:0][WIDTH-1:0] q;
  logic [2:0][WIDTH-1:0] v;
  logic [H_BITS-1:0]     pixelX;
  logic [V_BITS-1:0]     pixelY;

  modport master (output rayValid, q, v, pixelX, pixelY, input rayReady);
  modport slave  (input rayValid, q, v, pixelX, pixelY, output rayReady);
endinterface

// File: rtl/vec3_add.sv
// Combinational per-component wrapping add, or subtract when i_sub is set.
module vec3_add #(
  parameter int WIDTH = 16
) (
  input  logic [2:0][WIDTH-1:0] i_a,
  input  logic [2:0][WIDTH-1:0] i_b,
  input  logic                  i_sub,
  output logic [2:0][WIDTH-1:0] o_sum
);
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < 3; i++) begin
      o_sum[i] = i_sub ? (i_a[i] - i_b[i]) : (i_a[i] + i_b[i]);
    end
  end
endmodule

// File: rtl/ray_generator.sv
// Camera ray source: walks a 2^H_BITS x 2^V_BITS grid row-major, forming directions with adders only.
// Define RAY_GENERATOR_ABORT_EN to add an abort input that drops the frame from SETUP/EMIT.
module ray_generator
  import ray_pkg::*;
#(
  parameter int WIDTH  = RAY_WIDTH,
  parameter int H_BITS = 7,
  parameter int V_BITS = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
`ifdef RAY_GENERATOR_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [2:0][WIDTH-1:0] camPos,
  input  logic [2:0][WIDTH-1:0] camFwd,
  input  logic [2:0][WIDTH-1:0] camRight,
  input  logic [2:0][WIDTH-1:0] camDown,
  output logic                  busy,
  output logic                  frameDone,
  ray_generator_if.master       ray
);
  typedef logic [2:0][WIDTH-1:0] vec_t;

  gen_state_t        r_state;
  vec_t              r_pos;
  vec_t              r_fwd;
  vec_t              r_right;
  vec_t              r_down;
  vec_t              r_row_base;
  vec_t              r_v;
  logic [H_BITS-1:0] r_x;
  logic [V_BITS-1:0] r_y;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  vec_t w_right_sh;
  vec_t w_down_sh;
  vec_t w_fwd_less_right;
  vec_t w_row_first;
  vec_t w_v_next_col;
  vec_t w_row_next;
  logic w_fire;
  logic w_last_col;
  logic w_last_row;
  logic w_abort;

  // Offset of pixel (0,0) from screen centre: half a row of right steps, half a column of down steps.
  always_comb begin
    w_right_sh = '0;
    w_down_sh  = '0;
    for (int i = 0; i < 3; i++) begin
      w_right_sh[i] = r_right[i] << (H_BITS - 1);
      w_down_sh[i]  = r_down[i] << (V_BITS - 1);
    end
  end

  vec3_add #(.WIDTH(WIDTH)) u_setup_right (
    .i_a(r_fwd), .i_b(w_right_sh), .i_sub(1'b1), .o_sum(w_fwd_less_right)
  );
  vec3_add #(.WIDTH(WIDTH)) u_setup_down (
    .i_a(w_fwd_less_right), .i_b(w_down_sh), .i_sub(1'b1), .o_sum(w_row_first)
  );
  vec3_add #(.WIDTH(WIDTH)) u_col_step (
    .i_a(r_v), .i_b(r_right), .i_sub(1'b0), .o_sum(w_v_next_col)
  );
  vec3_add #(.WIDTH(WIDTH)) u_row_step (
    .i_a(r_row_base), .i_b(r_down), .i_sub(1'b0), .o_sum(w_row_next)
  );

  assign w_fire     = r_valid & ray.rayReady;
  assign w_last_col = &r_x;
  assign w_last_row = &r_y;

`ifdef RAY_GENERATOR_ABORT_EN
  assign w_abort = abort & ((r_state == SETUP) | (r_state == EMIT));
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pos      <= '0;
      r_fwd      <= '0;
      r_right    <= '0;
      r_down     <= '0;
      r_row_base <= '0;
      r_v        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_abort) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pos   <= camPos;
            r_fwd   <= camFwd;
            r_right <= camRight;
            r_down  <= camDown;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_row_base <= w_row_first;
          r_v        <= w_row_first;
          r_x        <= '0;
          r_y        <= '0;
          r_valid    <= 1'b1;
          r_state    <= EMIT;
        end
        EMIT: begin
          if (w_fire) begin
            if (!w_last_col) begin
              r_v <= w_v_next_col;
              r_x <= r_x + 1'b1;
            end else if (!w_last_row) begin
              r_row_base <= w_row_next;
              r_v        <= w_row_next;
              r_x        <= '0;
              r_y        <= r_y + 1'b1;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ray.rayValid = r_valid;
  assign ray.q        = r_pos;
  assign ray.v        = r_v;
  assign ray.pixelX   = r_x;
  assign ray.pixelY   = r_y;
  assign busy         = r_busy;
  assign frameDone    = r_done;
endmodule

// File: tb/tb_ray_generator.sv
// Self-checking bench for ray_generator on a 4x2 grid; directions checked against a closed-form model.
module tb_ray_generator;
  localparam int W    = 16;
  localparam int HB   = 2;
  localparam int VB   = 1;
  localparam int HRES = 1 << HB;
  localparam int VRES = 1 << VB;
  localparam int NPIX = HRES * VRES;

  typedef logic [2:0][W-1:0] vec_t;

  logic clock = 1'b0;
  logic reset;
  logic start;
  vec_t camPos, camFwd, camRight, camDown;
  logic busy, frameDone;
`ifdef RAY_GENERATOR_ABORT_EN
  logic abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ray_generator_if #(.WIDTH(W), .H_BITS(HB), .V_BITS(VB)) rif ();

  ray_generator #(.WIDTH(W), .H_BITS(HB), .V_BITS(VB)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
`ifdef RAY_GENERATOR_ABORT_EN
    .abort(abort),
`endif
    .camPos(camPos),
    .camFwd(camFwd),
    .camRight(camRight),
    .camDown(camDown),
    .busy(busy),
    .frameDone(frameDone),
    .ray(rif)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    vec_t r;
    r[0] = x;
    r[1] = y;
    r[2] = z;
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    return mk(W'($urandom), W'($urandom), W'($urandom));
  endfunction

  // v(x,y) = fwd + (x - HRES/2)*right + (y - VRES/2)*down, wrapped to W bits
  function automatic vec_t ref_v(input vec_t fwd, input vec_t right, input vec_t down,
                                 input int x, input int y);
    vec_t   r;
    longint s;
    for (int i = 0; i < 3; i++) begin
      s = longint'(fwd[i]) + longint'(x - HRES / 2) * longint'(right[i])
          + longint'(y - VRES / 2) * longint'(down[i]);
      r[i] = s[W-1:0];
    end
    return r;
  endfunction

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
  task automatic run_frame(input vec_t pos, input vec_t fwd, input vec_t right, input vec_t down,
                           input int mode, input int stop, input bit mid_start);
    int            idx;
    int            guard;
    bit            held;
    vec_t          pv;
    vec_t          ev;
    logic [HB-1:0] px, ex;
    logic [VB-1:0] py, ey;
    camPos = pos;
    camFwd = fwd;
    camRight = right;
    camDown = down;
    rif.rayReady = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("setup_busy", busy, 1);
    check("setup_valid", rif.rayValid, 0);
    step();
    check("first_valid", rif.rayValid, 1);
    idx = 0;
    guard = 0;
    held = 0;
    pv = '0;
    px = '0;
    py = '0;
    while (idx < stop && guard < 1000 && rif.rayValid) begin
      if (held) check("hold", {rif.v, rif.pixelX, rif.pixelY}, {pv, px, py});
      case (mode)
        0:       rif.rayReady = 1'b1;
        1:       rif.rayReady = (guard % 3 == 0);
        default: rif.rayReady = 1'($urandom_range(0, 1));
      endcase
      if (rif.rayReady) begin
        ev = ref_v(fwd, right, down, idx % HRES, idx / HRES);
        ex = HB'(idx % HRES);
        ey = VB'(idx / HRES);
        check("ray_v", rif.v, ev);
        check("ray_q", rif.q, pos);
        check("ray_xy", {rif.pixelX, rif.pixelY}, {ex, ey});
        idx++;
        held = 0;
      end else begin
        held = 1;
        pv = rif.v;
        px = rif.pixelX;
        py = rif.pixelY;
      end
      if (mid_start && guard == 3) begin
        start = 1'b1;
        camPos = ~pos;
        camFwd = ~fwd;
        camRight = ~right;
      end
      step();
      start = 1'b0;
      rif.rayReady = 1'b0;
      guard++;
    end
    check("ray_count", idx, stop);
    if (stop == NPIX) begin
      check("done_pulse", frameDone, 1);
      check("done_busy", busy, 0);
      check("done_valid", rif.rayValid, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("done_start_ignored", busy, 0);
      check("done_pulse_len", frameDone, 0);
    end
  endtask

  initial begin
    bit quiet;
    reset = 1'b1;
    start = 1'b0;
    rif.rayReady = 1'b0;
    camPos = '0;
    camFwd = '0;
    camRight = '0;
    camDown = '0;
`ifdef RAY_GENERATOR_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) step();
    check("rst_valid", rif.rayValid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frameDone, 0);
    check("rst_xy", {rif.pixelX, rif.pixelY}, 0);
    check("rst_qv", {rif.q, rif.v}, 0);
    reset = 1'b0;
    step();

    run_frame(mk(16'd5, 16'd6, 16'd7), mk(0, 0, 16'd100), mk(1, 0, 0), mk(0, 1, 0), 0, NPIX, 0);
    run_frame(mk(16'd5, 16'd6, 16'd7), mk(0, 0, 16'd100), mk(1, 0, 0), mk(0, 1, 0), 1, NPIX, 0);
    run_frame(mk(0, 0, 0), mk(0, 0, 0), mk(16'h4000, 0, 0), mk(0, 16'h0010, 0), 0, NPIX, 0);
    run_frame(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 2, NPIX, 1);

    run_frame(mk(16'h1234, 0, 0), mk(0, 0, 16'd100), mk(1, 0, 0), mk(0, 1, 0), 0, 3, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", rif.rayValid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", frameDone, 0);
    step();
    check("midrst_done_late", frameDone, 0);
    run_frame(mk(16'h1234, 0, 0), mk(0, 0, 16'd100), mk(1, 0, 0), mk(0, 1, 0), 0, NPIX, 0);

    for (int k = 0; k < 3; k++) begin
      run_frame(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 2, NPIX, 0);
    end

`ifdef RAY_GENERATOR_ABORT_EN
    run_frame(mk(1, 2, 3), mk(0, 0, 16'd100), mk(1, 0, 0), mk(0, 1, 0), 0, 2, 0);
    rif.rayReady = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    rif.rayReady = 1'b0;
    check("abort_valid", rif.rayValid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", frameDone, 0);
    quiet = 1'b0;
    repeat (5) begin
      step();
      quiet = quiet | rif.rayValid | frameDone;
    end
    check("abort_quiet", quiet, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
